// File: rtl/clk_en_gen_if.sv
// rtl/clk_en_gen_if.sv - Config/status bundle between a rate programmer and clk_en_gen
interface clk_en_gen_if #(
    parameter int NUM_CH = 3,
    parameter int ACC_W  = 16
);
    logic [NUM_CH*ACC_W-1:0] cfg_num;
    logic [NUM_CH*ACC_W-1:0] cfg_den;
    logic                    hold;
    logic [NUM_CH-1:0]       ce;
    logic [NUM_CH-1:0]       ce_n;
    logic [NUM_CH-1:0]       cfg_err;
    logic                    locked;

    modport master (
        output cfg_num, cfg_den, hold,
        input  ce, ce_n, cfg_err, locked
    );

    modport slave (
        input  cfg_num, cfg_den, hold,
        output ce, ce_n, cfg_err, locked
    );
endinterface

// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - Multi-channel fractional clock-enable generator with lock indication
// Optional mid-period ce_n pulses are built when CLK_EN_GEN_CEN_EN is defined.
module clk_en_gen #(
    parameter int NUM_CH      = 3,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 64
) (
    input  logic        refclk,
    input  logic        rst,
    clk_en_gen_if.slave bus
);
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic {SETTLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    locked_q, locked_d;
    logic [NUM_CH*ACC_W-1:0] num_q, den_q;
    logic                    cfg_chg;
    logic                    ch_clr;
    logic                    ch_adv;

    assign cfg_chg    = (bus.cfg_num != num_q) || (bus.cfg_den != den_q);
    assign bus.locked = locked_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            num_q    <= '0;
            den_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            if (cfg_chg) begin
                num_q <= bus.cfg_num;
                den_q <= bus.cfg_den;
            end
        end
    end

    // A config change outranks everything, including hold and the lock edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        ch_clr   = 1'b0;
        ch_adv   = 1'b0;
        if (cfg_chg) begin
            state_d  = SETTLE;
            cnt_d    = '0;
            locked_d = 1'b0;
            ch_clr   = 1'b1;
        end else begin
            case (state_q)
                SETTLE: begin
                    ch_clr = 1'b1;
                    if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_d  = RUN;
                        locked_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    locked_d = 1'b1;
                    ch_adv   = 1'b1;
                end
                default: state_d = SETTLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] num, den;
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [ACC_W:0]   sum, diff;
        logic             wrap, err, ce_q, ce_d;

        assign num  = num_q[i*ACC_W +: ACC_W];
        assign den  = den_q[i*ACC_W +: ACC_W];
        assign err  = (den == '0) || (num == '0) || (num > den);
        assign sum  = {1'b0, acc_q} + {1'b0, num};
        assign diff = sum - {1'b0, den};
        assign wrap = (sum >= {1'b0, den});

        assign bus.cfg_err[i] = err;
        assign bus.ce[i]      = ce_q;

        // Clearing during SETTLE makes every channel restart from phase 0 together.
        always_comb begin
            acc_d = acc_q;
            ce_d  = 1'b0;
            if (ch_clr || err) begin
                acc_d = '0;
            end else if (ch_adv && !bus.hold) begin
                acc_d = wrap ? diff[ACC_W-1:0] : sum[ACC_W-1:0];
                ce_d  = wrap;
            end
        end

        always_ff @(posedge refclk) begin
            if (rst) begin
                acc_q <= '0;
                ce_q  <= 1'b0;
            end else begin
                acc_q <= acc_d;
                ce_q  <= ce_d;
            end
        end

`ifdef CLK_EN_GEN_CEN_EN
        logic [ACC_W-1:0] half;
        logic             cen_q, cen_d;

        assign half          = den >> 1;
        assign bus.ce_n[i]   = cen_q;

        // Pulse when the accumulator crosses half of den, i.e. mid-way between ce pulses.
        always_comb begin
            cen_d = 1'b0;
            if (!ch_clr && !err && ch_adv && !bus.hold) begin
                if (wrap) cen_d = (diff[ACC_W-1:0] >= half);
                else      cen_d = (acc_q < half) && (half <= sum[ACC_W-1:0]);
            end
        end

        always_ff @(posedge refclk) begin
            if (rst) cen_q <= 1'b0;
            else     cen_q <= cen_d;
        end
`else
        assign bus.ce_n[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb/tb_clk_en_gen.sv - Scoreboard bench for clk_en_gen (honours CLK_EN_GEN_CEN_EN)
module tb_clk_en_gen;
    localparam int NC = 3;
    localparam int AW = 16;
    localparam int LC = 64;
    localparam int EW = 3*NC + 1;

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    clk_en_gen_if #(.NUM_CH(NC), .ACC_W(AW)) bus ();

    clk_en_gen #(.NUM_CH(NC), .ACC_W(AW), .LOCK_CYCLES(LC)) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    int n_cmp = 0;
    int n_err = 0;

    int m_num[NC];
    int m_den[NC];
    int m_acc[NC];
    int m_cnt;
    bit m_settle;
    bit m_locked;

    logic [EW-1:0] sb_q[$];
    logic          s_locked;
    logic [NC-1:0] s_ce, s_cen, s_err;
    logic [NC-1:0] h_ce[1024];
    logic [NC-1:0] h_cen[1024];
    bit            settle_ce;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int ch, input int num, input int den);
        bus.cfg_num[ch*AW +: AW] = AW'(num);
        bus.cfg_den[ch*AW +: AW] = AW'(den);
    endtask

    function automatic bit m_bad(input int i);
        return (m_den[i] == 0) || (m_num[i] == 0) || (m_num[i] > m_den[i]);
    endfunction

    // Advance the reference model by one edge, queue its prediction, then compare.
    task automatic tick();
        logic [NC-1:0] e_ce, e_cen, e_err;
        bit chg;
        int sum, r, half;
        e_ce  = '0;
        e_cen = '0;
        chg   = 1'b0;
        for (int i = 0; i < NC; i++)
            if (int'(bus.cfg_num[i*AW +: AW]) != m_num[i] || int'(bus.cfg_den[i*AW +: AW]) != m_den[i])
                chg = 1'b1;
        if (rst) begin
            m_settle = 1'b1; m_cnt = 0; m_locked = 1'b0;
            for (int i = 0; i < NC; i++) begin m_num[i] = 0; m_den[i] = 0; m_acc[i] = 0; end
        end else if (chg) begin
            for (int i = 0; i < NC; i++) begin
                m_num[i] = int'(bus.cfg_num[i*AW +: AW]);
                m_den[i] = int'(bus.cfg_den[i*AW +: AW]);
                m_acc[i] = 0;
            end
            m_settle = 1'b1; m_cnt = 0; m_locked = 1'b0;
        end else if (m_settle) begin
            if (m_cnt == LC - 1) begin m_settle = 1'b0; m_locked = 1'b1; end
            else m_cnt++;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (m_bad(i)) m_acc[i] = 0;
                else if (!bus.hold) begin
                    sum  = m_acc[i] + m_num[i];
                    half = m_den[i] / 2;
                    if (sum >= m_den[i]) begin
                        r = sum - m_den[i]; e_ce[i] = 1'b1; e_cen[i] = (r >= half);
                    end else begin
                        r = sum; e_cen[i] = (m_acc[i] < half) && (half <= r);
                    end
                    m_acc[i] = r;
                end
            end
        end
`ifndef CLK_EN_GEN_CEN_EN
        e_cen = '0;
`endif
        for (int i = 0; i < NC; i++) e_err[i] = m_bad(i);
        sb_q.push_back({m_locked, e_ce, e_cen, e_err});
        @(posedge refclk);
        #1;
        s_locked = bus.locked;
        s_ce     = bus.ce;
        s_cen    = bus.ce_n;
        s_err    = bus.cfg_err;
        check_eq("sb", 32'({s_locked, s_ce, s_cen, s_err}), 32'(sb_q.pop_front()));
    endtask

    task automatic record(input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            h_ce[k]  = s_ce;
            h_cen[k] = s_cen;
        end
    endtask

    task automatic wait_lock(output int zeros);
        zeros     = 0;
        settle_ce = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (s_locked) return;
            zeros++;
            if (s_ce != '0) settle_ce = 1'b1;
        end
        check_eq("lock_timeout", 32'(0), 32'(1));
    endtask

    function automatic int count_ch(input int ch, input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (h_ce[k][ch]) c++;
        return c;
    endfunction

    function automatic int first_ch(input int ch, input int n);
        for (int k = 1; k <= n; k++) if (h_ce[k][ch]) return k;
        return 0;
    endfunction

    function automatic int mask8(input int ch);
        int m = 0;
        for (int k = 1; k <= 8; k++) if (h_ce[k][ch]) m |= (1 << (k - 1));
        return m;
    endfunction

    initial begin
        int z;
        logic [NC-1:0] acc_or;
        bus.hold    = 1'b0;
        bus.cfg_num = '0;
        bus.cfg_den = '0;
        set_ch(0, 1, 2);
        set_ch(1, 3, 8);
        set_ch(2, 1, 16);

        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_locked", 32'(s_locked), 32'(0));
        check_eq("rst_ce", 32'(s_ce), 32'(0));
        rst = 1'b0;
        wait_lock(z);
        check_eq("lock_latency", 32'(z), 32'(64));
        check_eq("settle_ce", 32'(settle_ce), 32'(0));

        record(800);
        check_eq("ch0_first_ce", 32'(first_ch(0, 800)), 32'(2));
        check_eq("ch0_rate", 32'(count_ch(0, 800)), 32'(400));
        check_eq("ch1_phase", 32'(mask8(1)), 32'h0000_00a4);
        check_eq("ch1_rate", 32'(count_ch(1, 800)), 32'(300));
        check_eq("ch2_first_ce", 32'(first_ch(2, 800)), 32'(16));
        check_eq("ch2_rate", 32'(count_ch(2, 800)), 32'(50));
`ifdef CLK_EN_GEN_CEN_EN
        begin
            int pairs = 0;
            for (int k = 1; k + 8 <= 800; k++) if (h_ce[k][2] && h_cen[k+8][2]) pairs++;
            check_eq("ch2_cen_offset", 32'(pairs), 32'(49));
        end
`endif

        // ch1 phase is 0 here; two steps leave acc at 6 before freezing.
        repeat (2) tick();
        bus.hold = 1'b1;
        acc_or   = '0;
        repeat (10) begin tick(); acc_or |= s_ce | s_cen; end
        check_eq("hold_quiet", 32'(acc_or), 32'(0));
        check_eq("hold_locked", 32'(s_locked), 32'(1));
        bus.hold = 1'b0;
        record(8);
        check_eq("hold_resume", 32'(mask8(1)), 32'h0000_0029);

        set_ch(1, 3, 4);
        tick();
        check_eq("chg_locked_drop", 32'(s_locked), 32'(0));
        wait_lock(z);
        check_eq("chg_settle_len", 32'(z + 1), 32'(64));
        check_eq("chg_settle_ce", 32'(settle_ce), 32'(0));
        record(8);
        check_eq("chg_ch1_rate", 32'(count_ch(1, 8)), 32'(6));
        check_eq("chg_ch0_align", 32'(first_ch(0, 8)), 32'(2));
        check_eq("chg_ch2_align", 32'(count_ch(2, 8)), 32'(0));

        set_ch(0, 1, 0);
        set_ch(1, 5, 4);
        set_ch(2, 7, 7);
        tick();
        check_eq("cfg_err", 32'(s_err), 32'b011);
        wait_lock(z);
        record(20);
        check_eq("err_ch0_quiet", 32'(count_ch(0, 20)), 32'(0));
        check_eq("err_ch1_quiet", 32'(count_ch(1, 20)), 32'(0));
        check_eq("eq_ch2_high", 32'(count_ch(2, 20)), 32'(20));

        set_ch(0, 1, 2);
        set_ch(1, 3, 8);
        set_ch(2, 1, 16);
        wait_lock(z);
        record(5);
        bus.hold = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_eq("hold_rst_locked", 32'(s_locked), 32'(0));
        check_eq("hold_rst_ce", 32'(s_ce | s_cen), 32'(0));
        check_eq("hold_rst_err", 32'(s_err), 32'b111);
        rst      = 1'b0;
        bus.hold = 1'b0;
        wait_lock(z);
        check_eq("relock_latency", 32'(z), 32'(64));
        record(4);
        check_eq("relock_ch0", 32'(first_ch(0, 4)), 32'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Parametrised multi-channel fractional clock-enable generator, one per core.
- Runs off a single fast system clock (e.g. 96 MHz) and produces NUM_CH single-cycle enable pulses at runtime-programmable rates num/den × f_clk (e.g. 48 MHz, 6 MHz).
- Replaces fixed-ratio secondary clocks: all logic stays in one clock domain and ratios change without reconfiguring any PLL.
- Provides a PLL-style `locked` indication after reset or after any ratio change.

Parameters:
- NUM_CH, 3, number of enable channels (1..8).
- ACC_W, 16, width of the per-channel num/den and of the phase accumulator.
- LOCK_CYCLES, 64, settle cycles after reset or config change before `locked` asserts (≥1).

Ports:
- refclk  in  1  system clock; every register is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_num  in  NUM_CH*ACC_W  per-channel numerator; channel i occupies bits [i*ACC_W +: ACC_W].
- cfg_den  in  NUM_CH*ACC_W  per-channel denominator, same packing.
- hold  in  1  freezes all accumulators and forces every `ce`/`ce_n` to 0; `locked` is unaffected.
- ce  out  NUM_CH  registered enable pulses, one bit per channel.
- ce_n  out  NUM_CH  mid-period enable pulses (optional feature); tied to 0 when the feature is compiled out.
- cfg_err  out  NUM_CH  channel configuration invalid.
- locked  out  1  outputs are valid and phase-aligned.

Behaviour:
- Reset (rst=1 at an edge): on the next edge, ce=0, ce_n=0, locked=0, all accumulators=0, settle counter=0, shadow config=0, FSM=SETTLE. This applies equally when rst asserts mid-operation.
- cfg_err[i]: combinational from the shadow config. Asserted when den==0, num==0, or num>den. An erroneous channel holds acc=0 and ce[i]=ce_n[i]=0. Other channels are unaffected.
- FSM states:
  - SETTLE: counter increments every cycle; accumulators are held at 0; ce=0; locked=0. When counter==LOCK_CYCLES-1, go to RUN. On that same edge locked becomes 1 and all accumulators start from 0, so every channel is phase-aligned.
  - RUN: locked=1; channels advance.
- Config change: every cycle the cfg inputs are compared with the shadow registers. On any difference, the shadow is updated, the counter is cleared, and the FSM enters SETTLE on the next edge; locked drops that same edge. A change arriving while already in SETTLE restarts the count.
- Channel update, in RUN with hold=0 and no cfg_err:
  - sum = acc + num, computed at ACC_W+1 bits (no overflow).
  - If sum ≥ den: acc ← sum−den and ce[i] ← 1. Otherwise: acc ← sum and ce[i] ← 0.
  - Latency: ce reflects the update on the same edge as acc, i.e. 1 cycle after the accumulate decision.
  - Invariant: acc < den at all times.
- num == den gives ce permanently high. This is legal.
- hold=1 has priority over channel update: acc keeps its value; ce and ce_n go to 0 on the next edge. On release, the channel resumes from the held acc (no phase loss).
- Simultaneous config change and hold: the config change wins (SETTLE).

Optional Feature:
- Macro CLK_EN_GEN_CEN_EN.
- Defined: per channel, half = den>>1. ce_n[i] ← 1 on the edge where the new acc value r satisfies one of:
  - no wrap, and acc_prev < half ≤ r; or
  - wrap, and r ≥ half.
  - This yields a pulse roughly mid-way between ce pulses, intended for negative-phase CPU/video enables.
  - ce_n is gated by hold, cfg_err and locked exactly like ce.
  - For num > half, ce_n pattern accuracy is best-effort; it is only required to be deterministic.
- Undefined: ce_n is constant 0 and no half-compare logic is synthesised.

Test Plan:
- Reset/lock, LOCK_CYCLES=64: rst high 3 cycles then low.
  - Required: locked=0 and ce=0 for exactly 64 cycles after rst falls, then locked=1.
  - Required: channel 0 with num=1, den=2 gives its first ce 2 cycles after lock, then every 2nd cycle.
- Fractional ratio: ch1 num=3, den=8.
  - Required: ce high on cycles 3, 6 and 8 of each 8-cycle window after lock (acc sequence 3,6,1,4,7,2,5,0); exactly 3 pulses per 8 cycles over 800 cycles.
- Divide-by-16: ch2 num=1, den=16.
  - Required: ce every 16th cycle.
  - Required (macro on): ce_n occurs 8 cycles after each ce.
- Config change mid-run: change ch1 den 8→4.
  - Required: locked low on the next edge and all ce=0 for 64 cycles.
  - Required: afterwards all channels restart aligned, with ch1 pulsing 3 of every 4 cycles.
- Errors and edges: ch0 den=0, ch1 num=5/den=4, ch2 num=den=7.
  - Required: cfg_err=3'b011; ce[1:0] stay 0; ce[2] constantly high after lock.
- Hold: assert hold for 10 cycles during a 3/8 run.
  - Required: ce=0 throughout; acc frozen; pulse pattern resumes from the frozen phase.
  - Required: rst asserted mid-hold clears everything on the next edge.
